cp0_irq_ctrl: RTL and testbench

Parametrised coprocessor-0 exception/interrupt controller for the MIPS core; successor to the fixed three-source CP0. It latches up to NUM_SRC edge-triggered exception requests, applies per-source masking and a global enable, and selects the lowest-index unmasked source by fixed priority. On selection it captures the return PC and vectors the fetch stage to a per-source handler address. It is fully synchronous, with one clock and no derived clocks, and sits beside the decode/writeback stages (mfc0/mtc0/eret).

---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_prio_enc.sv | 28 ++
 rtl/cp0_irq_ctrl.sv | 134 +++++++++++++
 tb/tb_cp0_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_pkg                                                              |
// | Shared CP0 register selects, STATUS bit indices and CAUSE layout.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cp0_pkg;

    localparam logic [1:0] SEL_EPC    = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_MASK   = 2'd2;
    localparam logic [1:0] SEL_CAUSE  = 2'd3;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;

    localparam int CAUSE_CODE_LSB = 0;
    localparam int CAUSE_CODE_W   = 5;
    localparam int CAUSE_PEND_LSB = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_prio_enc                                                         |
// | Fixed-priority encoder: lowest set request index wins.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cp0_prio_enc
    import cp0_pkg::*;
#(
    parameter int NUM_SRC = 8,
    localparam int IDX_W  = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cp0_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_irq_ctrl                                                         |
// | CP0 exception controller: edge-latched requests, mask, priority,    |
// | EPC capture, handler vectoring and eret return.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cp0_irq_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_SRC  = 8,
    parameter logic [31:0] VEC_BASE = 32'h0000_4000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               accept_i,
    input  logic [31:0]        pc_i,
    input  logic               wr_en_i,
    input  logic [1:0]         sel_i,
    input  logic [31:0]        wr_data_i,
    input  logic               eret_i,
    output logic [31:0]        rd_data_o,
    output logic               redir_valid_o,
    output logic [31:0]        redir_pc_o,
    output logic               exl_o
);

    localparam int IDX_W = idx_width(NUM_SRC);

    logic [31:0]             r_epc;
    logic                    r_ie;
    logic                    r_exl;
    logic [NUM_SRC-1:0]      r_mask;
    logic [CAUSE_CODE_W-1:0] r_code;
    logic [NUM_SRC-1:0]      r_pend;
    logic [NUM_SRC-1:0]      r_src_q;
    logic                    r_redir_valid;
    logic [31:0]             r_redir_pc;

    logic               w_elig_valid;
    logic [IDX_W-1:0]   w_idx;
    logic               w_take;
    logic               w_eret;
    logic               w_wr_epc;
    logic               w_wr_status;
    logic               w_wr_mask;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_take_clr;
    logic [NUM_SRC-1:0] w_rise;
    logic [31:0]        w_vec;

    cp0_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .req   (r_pend & r_mask),
        .valid (w_elig_valid),
        .idx   (w_idx)
    );

    assign w_take      = r_ie & ~r_exl & accept_i & w_elig_valid;
    assign w_eret      = eret_i & r_exl;
    assign w_wr_epc    = wr_en_i & (sel_i == SEL_EPC);
    assign w_wr_status = wr_en_i & (sel_i == SEL_STATUS);
    assign w_wr_mask   = wr_en_i & (sel_i == SEL_MASK);
    assign w_w1c       = (wr_en_i && sel_i == SEL_CAUSE) ?
                         wr_data_i[CAUSE_PEND_LSB +: NUM_SRC] : '0;
    assign w_rise      = src_i & ~r_src_q;
    assign w_vec       = VEC_BASE + (32'(w_idx) << 3);

    always_comb begin
        w_take_clr = '0;
        if (w_take) w_take_clr[w_idx] = 1'b1;
    end

    // A fresh edge in the same cycle as a clear re-arms the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc         <= '0;
            r_ie          <= 1'b0;
            r_exl         <= 1'b0;
            r_mask        <= '0;
            r_code        <= '0;
            r_pend        <= '0;
            r_src_q       <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
        end else begin
            r_src_q <= src_i;
            r_pend  <= (r_pend & ~w_w1c & ~w_take_clr) | w_rise;

            if (w_take) begin
                r_epc  <= pc_i;
                r_code <= CAUSE_CODE_W'(w_idx) + CAUSE_CODE_W'(1);
            end else if (w_wr_epc) begin
                r_epc <= wr_data_i;
            end

            if (w_wr_status) r_ie <= wr_data_i[ST_IE];

            if (w_take)           r_exl <= 1'b1;
            else if (w_eret)      r_exl <= 1'b0;
            else if (w_wr_status) r_exl <= wr_data_i[ST_EXL];

            if (w_wr_mask) r_mask <= wr_data_i[NUM_SRC-1:0];

            r_redir_valid <= w_take | w_eret;
            if (w_take)      r_redir_pc <= w_vec;
            else if (w_eret) r_redir_pc <= r_epc;
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (sel_i)
            SEL_EPC:    rd_data_o = r_epc;
            SEL_STATUS: begin
                rd_data_o[ST_IE]  = r_ie;
                rd_data_o[ST_EXL] = r_exl;
            end
            SEL_MASK:   rd_data_o[NUM_SRC-1:0] = r_mask;
            default: begin
                rd_data_o[CAUSE_CODE_LSB +: CAUSE_CODE_W] = r_code;
                rd_data_o[CAUSE_PEND_LSB +: NUM_SRC]      = r_pend;
            end
        endcase
    end

    assign redir_valid_o = r_redir_valid;
    assign redir_pc_o    = r_redir_pc;
    assign exl_o         = r_exl;

endmodule
`default_nettype wire

// File: tb/tb_cp0_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cp0_irq_ctrl                                                      |
// | Directed and random stimulus against a behavioural CP0 model.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cp0_irq_ctrl;

    localparam int          N  = 8;
    localparam logic [31:0] VB = 32'h0000_4000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] src = '0;
    logic         accept = 1'b0;
    logic [31:0]  pc = '0;
    logic         wr_en = 1'b0;
    logic [1:0]   sel = '0;
    logic [31:0]  wdata = '0;
    logic         eret = 1'b0;
    logic [31:0]  rd_data;
    logic         redir_valid;
    logic [31:0]  redir_pc;
    logic         exl;

    always #5 clk = ~clk;

    cp0_irq_ctrl #(
        .NUM_SRC  (N),
        .VEC_BASE (VB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_i         (src),
        .accept_i      (accept),
        .pc_i          (pc),
        .wr_en_i       (wr_en),
        .sel_i         (sel),
        .wr_data_i     (wdata),
        .eret_i        (eret),
        .rd_data_o     (rd_data),
        .redir_valid_o (redir_valid),
        .redir_pc_o    (redir_pc),
        .exl_o         (exl)
    );

    // Behavioural model: architectural state as plain variables and arrays.
    bit [31:0] m_epc;
    bit        m_ie, m_exl;
    bit        m_mask [N];
    bit        m_pend [N];
    bit        m_srcq [N];
    int        m_code;
    bit        m_rv;
    bit [31:0] m_rpc;

    int vectors = 0;
    int errors  = 0;

    task automatic model_reset();
        m_epc = '0; m_ie = 0; m_exl = 0; m_code = 0; m_rv = 0; m_rpc = '0;
        for (int i = 0; i < N; i++) begin
            m_mask[i] = 0; m_pend[i] = 0; m_srcq[i] = 0;
        end
    endtask

    // One clock edge of architectural behaviour using the current inputs.
    task automatic model_step();
        int        pick;
        bit        do_eret;
        bit [31:0] old_epc;
        pick = -1;
        if (m_ie && !m_exl && accept) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i] && m_mask[i]) begin
                    pick = i;
                    break;
                end
            end
        end
        do_eret = eret && m_exl;
        old_epc = m_epc;
        if (wr_en) begin
            case (sel)
                2'd0: m_epc = wdata;
                2'd1: begin m_ie = wdata[0]; m_exl = wdata[1]; end
                2'd2: for (int i = 0; i < N; i++) m_mask[i] = wdata[i];
                default: for (int i = 0; i < N; i++) if (wdata[16+i]) m_pend[i] = 0;
            endcase
        end
        if (do_eret) m_exl = 0;
        if (pick >= 0) begin
            m_epc  = pc;
            m_exl  = 1;
            m_code = pick + 1;
            m_pend[pick] = 0;
        end
        m_rv = (pick >= 0) || do_eret;
        if (pick >= 0)    m_rpc = VB + 32'(pick * 8);
        else if (do_eret) m_rpc = old_epc;
        for (int i = 0; i < N; i++) begin
            if (src[i] && !m_srcq[i]) m_pend[i] = 1;
            m_srcq[i] = src[i];
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] s);
        logic [31:0] v;
        v = '0;
        case (s)
            2'd0: v = m_epc;
            2'd1: begin v[0] = m_ie; v[1] = m_exl; end
            2'd2: for (int i = 0; i < N; i++) v[i] = m_mask[i];
            default: begin
                v[4:0] = 5'(m_code);
                for (int i = 0; i < N; i++) v[16+i] = m_pend[i];
            end
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called in the low phase: checks readback, clocks, then checks outputs.
    task automatic cycle();
        #1;
        check("rd_data", rd_data, exp_rd(sel));
        @(posedge clk);
        model_step();
        #1;
        check("redir_valid", 32'(redir_valid), 32'(m_rv));
        if (m_rv) check("redir_pc", redir_pc, m_rpc);
        check("exl", 32'(exl), 32'(m_exl));
        @(negedge clk);
    endtask

    task automatic step(input logic [N-1:0] s, input logic acc, input logic [31:0] p,
                        input logic we, input logic [1:0] sl, input logic [31:0] wd,
                        input logic er);
        src = s; accept = acc; pc = p; wr_en = we; sel = sl; wdata = wd; eret = er;
        cycle();
    endtask

    task automatic idle(input logic acc);
        step('0, acc, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0);
    endtask

    task automatic peek(input logic [1:0] s, input string name,
                        input logic [31:0] msk, input logic [31:0] exp);
        wr_en = 0; eret = 0; accept = 0; sel = s;
        #1;
        check(name, rd_data & msk, exp);
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_redir_valid", 32'(redir_valid), 32'h0);
        check("rst_exl", 32'(exl), 32'h0);
        check("rst_redir_pc", redir_pc, 32'h0);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) peek(2'(s), "rst_rd", 32'hFFFF_FFFF, 32'h0);
        rst_n = 1'b1;

        // Single source take
        step('0, 0, 0, 1, 2'd2, 32'hFF, 0);
        step('0, 0, 0, 1, 2'd1, 32'h1, 0);
        step(8'h08, 1, 32'h100, 0, 2'd0, 0, 0);
        step(8'h08, 1, 32'h100, 0, 2'd0, 0, 0);
        check("t1_redir_valid", 32'(redir_valid), 32'h1);
        check("t1_redir_pc", redir_pc, 32'h4018);
        check("t1_exl", 32'(exl), 32'h1);
        peek(2'd0, "t1_epc", 32'hFFFF_FFFF, 32'h100);
        peek(2'd3, "t1_code", 32'h1F, 32'h4);
        idle(0);
        check("t1_one_cycle", 32'(redir_valid), 32'h0);
        step('0, 0, 0, 0, 2'd0, 0, 1);
        check("t1_eret_pc", redir_pc, 32'h100);

        // Two simultaneous sources: lower index first
        step(8'h24, 1, 32'h200, 0, 2'd0, 0, 0);
        step('0, 1, 32'h200, 0, 2'd0, 0, 0);
        check("t2_first", redir_pc, 32'h4010);
        step('0, 1, 32'h300, 0, 2'd0, 0, 1);
        check("t2_eret", redir_pc, 32'h200);
        step('0, 1, 32'h300, 0, 2'd0, 0, 0);
        check("t2_second", redir_pc, 32'h4028);
        step('0, 0, 0, 0, 2'd0, 0, 1);

        // Masked request stays pending until unmasked
        step('0, 0, 0, 1, 2'd2, 32'h0, 0);
        step(8'h02, 1, 0, 0, 2'd0, 0, 0);
        idle(1);
        check("t3_masked", 32'(redir_valid), 32'h0);
        peek(2'd3, "t3_pend", 32'h0002_0000, 32'h0002_0000);
        step('0, 1, 32'h400, 1, 2'd2, 32'h02, 0);
        step('0, 1, 32'h400, 0, 2'd0, 0, 0);
        check("t3_take", redir_pc, 32'h4008);
        step('0, 0, 0, 1, 2'd2, 32'hFF, 1);

        // Request during handler waits for eret
        step(8'h08, 1, 32'h500, 0, 2'd0, 0, 0);
        step('0, 1, 32'h500, 0, 2'd0, 0, 0);
        step(8'h01, 1, 32'h600, 0, 2'd0, 0, 0);
        idle(1);
        check("t4_blocked", 32'(redir_valid), 32'h0);
        step('0, 1, 32'h600, 0, 2'd0, 0, 1);
        check("t4_eret", redir_pc, 32'h500);
        step('0, 1, 32'h700, 0, 2'd0, 0, 0);
        check("t4_take0", redir_pc, 32'h4000);
        step('0, 0, 0, 0, 2'd0, 0, 1);

        // Set beats W1C on the same bit
        step(8'h01, 0, 0, 1, 2'd3, 32'h0001_0000, 0);
        peek(2'd3, "t5_set_wins", 32'h0001_0000, 32'h0001_0000);
        step(8'h01, 0, 0, 1, 2'd3, 32'h0001_0000, 0);
        peek(2'd3, "t5_w1c", 32'h0001_0000, 32'h0);

        // accept_i gating, then asynchronous reset in handler
        step(8'h10, 0, 32'h800, 0, 2'd0, 0, 0);
        repeat (3) idle(0);
        check("t6_no_accept", 32'(redir_valid), 32'h0);
        step('0, 1, 32'h800, 0, 2'd0, 0, 0);
        check("t6_take", redir_pc, 32'h4020);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_arst_exl", 32'(exl), 32'h0);
        check("t6_arst_rv", 32'(redir_valid), 32'h0);
        check("t6_arst_pc", redir_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] wd;
            logic [1:0]  sl;
            logic        we;
            sl = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 7) == 0);
            wd = $urandom;
            if (sl == 2'd1 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            if (sl == 2'd1 && $urandom_range(0, 1) != 0) wd[1] = 1'b0;
            step(($urandom_range(0, 2) == 0) ? N'($urandom) : src,
                 ($urandom_range(0, 3) != 0), $urandom, we, sl, wd,
                 ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
